// File: rtl/snake_move_ctrl_pkg.sv
// Shared move encodings and helpers for the snake direction controller.
// PS2 scan-code constants are compiled in only when SNAKE_PS2_INPUT_EN is defined.
package snake_move_ctrl_pkg;

  localparam int MOVE_W = 3;
  typedef logic [MOVE_W-1:0] move_t;

  localparam move_t MOVE_UP    = 3'd1;
  localparam move_t MOVE_RIGHT = 3'd2;
  localparam move_t MOVE_DOWN  = 3'd3;
  localparam move_t MOVE_LEFT  = 3'd4;
  localparam move_t MOVE_NONE  = 3'd5;

`ifdef SNAKE_PS2_INPUT_EN
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_W     = 8'h1D;
  localparam logic [7:0] PS2_D     = 8'h23;
  localparam logic [7:0] PS2_S     = 8'h1B;
  localparam logic [7:0] PS2_A     = 8'h1C;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
`endif

  // Up/down and right/left codes sit exactly two apart.
  function automatic logic is_opposite(input move_t a, input move_t b);
    move_t d;
    d = (a > b) ? (a - b) : (b - a);
    return (d == 3'd2);
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Player input / move output bundle for snake_move_ctrl.
// The PS2 key inputs exist only when SNAKE_PS2_INPUT_EN is defined.
interface snake_move_ctrl_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [4*NUM_PLAYERS-1:0] btn;
  logic                     tick;
  logic                     clear;
  logic [3*NUM_PLAYERS-1:0] move;
  logic [NUM_PLAYERS-1:0]   move_changed;
  logic [NUM_PLAYERS-1:0]   queue_full;
  logic [NUM_PLAYERS-1:0]   overflow;
`ifdef SNAKE_PS2_INPUT_EN
  logic                     ps2_key_pressed;
  logic [7:0]               ps2_out;

  modport master (
    output btn, tick, clear, ps2_key_pressed, ps2_out,
    input  move, move_changed, queue_full, overflow
  );
  modport slave (
    input  btn, tick, clear, ps2_key_pressed, ps2_out,
    output move, move_changed, queue_full, overflow
  );
`else
  modport master (
    output btn, tick, clear,
    input  move, move_changed, queue_full, overflow
  );
  modport slave (
    input  btn, tick, clear,
    output move, move_changed, queue_full, overflow
  );
`endif
endinterface

// File: rtl/snake_move_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter, stable level and press pulse.
// o_press is high for the single cycle in which the stable level becomes 1.
module snake_move_ctrl_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Counter only runs while the synced level disagrees with the stable level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
        r_press  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/snake_move_ctrl.sv
// Per-player direction controller: debounced presses, reversal/repeat filter, turn FIFO, tick-driven move.
// Define SNAKE_PS2_INPUT_EN to add PS2 keyboard events as a lower-priority source.
module snake_move_ctrl
  import snake_move_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  snake_move_ctrl_if.slave   bus
);

  localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNTW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(QUEUE_DEPTH);

  logic [4*NUM_PLAYERS-1:0] w_press;

  for (genvar b = 0; b < 4*NUM_PLAYERS; b++) begin : g_btn
    snake_move_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_btn  (bus.btn[b]),
      .o_press(w_press[b])
    );
  end

`ifdef SNAKE_PS2_INPUT_EN
  logic       r_ps2_break;
  logic [7:0] w_key_all;

  // The byte after a break code is a key release and must not count as a press.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ps2_break <= 1'b0;
    end else if (bus.ps2_key_pressed) begin
      if (bus.ps2_out == PS2_BREAK) begin
        r_ps2_break <= 1'b1;
      end else if (bus.ps2_out != PS2_EXT) begin
        r_ps2_break <= 1'b0;
      end else begin
        r_ps2_break <= r_ps2_break;
      end
    end else begin
      r_ps2_break <= r_ps2_break;
    end
  end

  always_comb begin
    w_key_all = 8'h00;
    if (bus.ps2_key_pressed && !r_ps2_break) begin
      case (bus.ps2_out)
        PS2_W:     w_key_all[3] = 1'b1;
        PS2_D:     w_key_all[2] = 1'b1;
        PS2_S:     w_key_all[1] = 1'b1;
        PS2_A:     w_key_all[0] = 1'b1;
        PS2_UP:    w_key_all[7] = 1'b1;
        PS2_RIGHT: w_key_all[6] = 1'b1;
        PS2_DOWN:  w_key_all[5] = 1'b1;
        PS2_LEFT:  w_key_all[4] = 1'b1;
        default:   w_key_all    = 8'h00;
      endcase
    end else begin
      w_key_all = 8'h00;
    end
  end
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]      w_btn_ev;
    logic [3:0]      w_ev;
    move_t           w_cand;
    logic            w_cand_vld;
    move_t           w_ref;
    logic [PW-1:0]   w_last;
    logic            w_full;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;

    move_t           r_q [QUEUE_DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CNTW-1:0] r_count;
    move_t           r_move;
    logic            r_changed;
    logic            r_overflow;

    assign w_btn_ev = w_press[4*p +: 4];

`ifdef SNAKE_PS2_INPUT_EN
    logic [3:0] w_key;
    if (p < 2) begin : g_key
      assign w_key = w_key_all[4*p +: 4];
    end else begin : g_nokey
      assign w_key = 4'b0000;
    end
    assign w_ev = (|w_btn_ev) ? w_btn_ev : w_key;
`else
    assign w_ev = w_btn_ev;
`endif

    // Bit order {up,right,down,left}; the highest set bit wins.
    always_comb begin
      w_cand     = MOVE_NONE;
      w_cand_vld = 1'b1;
      if (w_ev[3]) begin
        w_cand = MOVE_UP;
      end else if (w_ev[2]) begin
        w_cand = MOVE_RIGHT;
      end else if (w_ev[1]) begin
        w_cand = MOVE_DOWN;
      end else if (w_ev[0]) begin
        w_cand = MOVE_LEFT;
      end else begin
        w_cand_vld = 1'b0;
      end
    end

    assign w_last   = (r_tail == '0) ? PTR_LAST : (r_tail - PW'(1));
    assign w_ref    = (r_count != '0) ? r_q[w_last] : r_move;
    assign w_full   = (r_count == CNT_FULL);
    assign w_accept = w_cand_vld &&
                      ((w_ref == MOVE_NONE) || ((w_cand != w_ref) && !is_opposite(w_cand, w_ref)));
    assign w_pop    = bus.tick && (r_count != '0);
    assign w_push   = w_accept && (!w_full || w_pop);

    // Clear shares the reset action and therefore beats tick and new events.
    always_ff @(posedge i_clock) begin
      if (i_reset || bus.clear) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          r_q[i] <= MOVE_NONE;
        end
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_move     <= MOVE_NONE;
        r_changed  <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        r_changed  <= w_pop;
        r_overflow <= w_accept && w_full && !w_pop;
        if (w_pop) begin
          r_move <= r_q[r_head];
          r_head <= (r_head == PTR_LAST) ? '0 : (r_head + PW'(1));
        end
        if (w_push) begin
          r_q[r_tail] <= w_cand;
          r_tail      <= (r_tail == PTR_LAST) ? '0 : (r_tail + PW'(1));
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNTW'(1);
          2'b01:   r_count <= r_count - CNTW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    assign bus.move[3*p +: 3]  = r_move;
    assign bus.move_changed[p] = r_changed;
    assign bus.overflow[p]     = r_overflow;
    assign bus.queue_full[p]   = w_full;
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scenario bench for snake_move_ctrl: a reference filter/queue model predicts moves,
// and each tick pops the expected move for comparison with the DUT.
module tb_snake_move_ctrl;

  localparam int NP = 2;
  localparam int DB = 4;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_move_ctrl_if #(.NUM_PLAYERS(NP)) bus ();

  snake_move_ctrl #(
    .NUM_PLAYERS    (NP),
    .DEBOUNCE_CYCLES(DB),
    .QUEUE_DEPTH    (QD)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

`ifdef SNAKE_PS2_INPUT_EN
  initial begin
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_out         = 8'h00;
  end
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: current move and pending turns per player.
  int mmove  [NP];
  int mq     [NP][QD];
  int mcount [NP];
  int exp_ov [NP];
  int ov_cnt [NP];

  logic [5:0] obs_move, exp_move;
  logic [1:0] obs_mc, obs_mc_next, exp_mc;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (bus.overflow[p] === 1'b1) ov_cnt[p]++;
    end
  end

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      mmove[p]  = 5;
      mcount[p] = 0;
    end
  endfunction

  function automatic void model_pop(input int p);
    mmove[p] = mq[p][0];
    for (int i = 0; i < QD-1; i++) mq[p][i] = mq[p][i+1];
    mcount[p]--;
  endfunction

  // Accepted event; with_pop models a tick landing in the same cycle.
  function automatic void model_event(input int p, input int d, input bit with_pop);
    int r, diff;
    bit acc;
    r    = (mcount[p] > 0) ? mq[p][mcount[p]-1] : mmove[p];
    diff = (d > r) ? d - r : r - d;
    acc  = (r == 5) || ((d != r) && (diff != 2));
    if (with_pop && mcount[p] > 0) model_pop(p);
    if (acc) begin
      if (mcount[p] < QD) begin
        mq[p][mcount[p]] = d;
        mcount[p]++;
      end else begin
        exp_ov[p]++;
      end
    end
  endfunction

  function automatic int btn_idx(input int p, input int d);
    return 4*p + (4 - d);
  endfunction

  task automatic press(input int p, input int d, input int hold);
    bus.btn[btn_idx(p, d)] = 1'b1;
    repeat (hold) @(negedge clk);
    bus.btn[btn_idx(p, d)] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_tick();
    exp_mc = 2'b00;
    for (int p = 0; p < NP; p++) begin
      if (mcount[p] > 0) begin
        model_pop(p);
        exp_mc[p] = 1'b1;
      end
    end
    exp_move = {3'(mmove[1]), 3'(mmove[0])};
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    obs_move = bus.move;
    obs_mc   = bus.move_changed;
    @(negedge clk);
    obs_mc_next = bus.move_changed;
  endtask

  task automatic test_reset();
    bus.btn = '0; bus.tick = 1'b0; bus.clear = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.move !== 6'o55) begin n_fail++; $display("FAIL reset_move: got %h expected %h", bus.move, 6'o55); end
    n_tests++; if (bus.move_changed !== 2'b00) begin n_fail++; $display("FAIL reset_mc: got %b expected 00", bus.move_changed); end
    n_tests++; if (bus.overflow !== 2'b00) begin n_fail++; $display("FAIL reset_ov: got %b expected 00", bus.overflow); end
    n_tests++; if (bus.queue_full !== 2'b00) begin n_fail++; $display("FAIL reset_qf: got %b expected 00", bus.queue_full); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.move !== 6'o55) begin n_fail++; $display("FAIL post_reset_move: got %h expected %h", bus.move, 6'o55); end
  endtask

  task automatic test_basic_move();
    press(0, 2, 10);
    model_event(0, 2, 1'b0);
    pulse_tick();
    n_tests++; if (obs_mc !== 2'b01) begin n_fail++; $display("FAIL basic_mc: got %b expected 01", obs_mc); end
    n_tests++; if (obs_move !== exp_move) begin n_fail++; $display("FAIL basic_move: got %h expected %h", obs_move, exp_move); end
    n_tests++; if (obs_move[2:0] !== 3'd2) begin n_fail++; $display("FAIL basic_move_p0: got %0d expected 2", obs_move[2:0]); end
    n_tests++; if (obs_mc_next !== 2'b00) begin n_fail++; $display("FAIL basic_mc_width: got %b expected 00", obs_mc_next); end
  endtask

  // A 3-cycle blip of a non-repeat direction must not survive the debouncer.
  task automatic test_glitch();
    press(0, 1, 3);
    pulse_tick();
    n_tests++; if (obs_mc !== 2'b00) begin n_fail++; $display("FAIL glitch_mc: got %b expected 00", obs_mc); end
    n_tests++; if (obs_move[2:0] !== 3'd2) begin n_fail++; $display("FAIL glitch_move: got %0d expected 2", obs_move[2:0]); end
  endtask

  task automatic test_filter();
    int ov0;
    ov0 = ov_cnt[0];
    press(0, 4, 10); model_event(0, 4, 1'b0);
    press(0, 2, 10); model_event(0, 2, 1'b0);
    n_tests++; if (bus.queue_full !== 2'b00) begin n_fail++; $display("FAIL filter_rejects_qf: got %b expected 00", bus.queue_full); end
    press(0, 1, 10); model_event(0, 1, 1'b0);
    press(0, 3, 10); model_event(0, 3, 1'b0);
    press(0, 4, 10); model_event(0, 4, 1'b0);
    n_tests++; if (bus.queue_full !== 2'b01) begin n_fail++; $display("FAIL filter_qf: got %b expected 01", bus.queue_full); end
    press(0, 3, 10); model_event(0, 3, 1'b0);
    n_tests++; if (ov_cnt[0] - ov0 !== 1) begin n_fail++; $display("FAIL filter_overflow: got %0d pulses expected 1", ov_cnt[0] - ov0); end
    n_tests++; if (ov_cnt[0] !== exp_ov[0]) begin n_fail++; $display("FAIL filter_ov_model: got %0d expected %0d", ov_cnt[0], exp_ov[0]); end
  endtask

  // Press pulse appears 6 edges after the button rises; tick is lined up with its enqueue.
  task automatic test_tick_push();
    bus.btn[btn_idx(0, 3)] = 1'b1;
    repeat (6) @(negedge clk);
    model_event(0, 3, 1'b1);
    bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    n_tests++; if (bus.move[2:0] !== 3'd1) begin n_fail++; $display("FAIL tp_move: got %0d expected 1", bus.move[2:0]); end
    n_tests++; if (bus.move_changed !== 2'b01) begin n_fail++; $display("FAIL tp_mc: got %b expected 01", bus.move_changed); end
    n_tests++; if (bus.queue_full !== 2'b01) begin n_fail++; $display("FAIL tp_qf: got %b expected 01", bus.queue_full); end
    repeat (3) @(negedge clk);
    bus.btn[btn_idx(0, 3)] = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++; if (ov_cnt[0] !== exp_ov[0]) begin n_fail++; $display("FAIL tp_no_overflow: got %0d expected %0d", ov_cnt[0], exp_ov[0]); end
    for (int k = 0; k < 2; k++) begin
      pulse_tick();
      n_tests++; if (obs_move !== exp_move) begin n_fail++; $display("FAIL tp_drain%0d: got %h expected %h", k, obs_move, exp_move); end
      n_tests++; if (obs_mc !== exp_mc) begin n_fail++; $display("FAIL tp_drain_mc%0d: got %b expected %b", k, obs_mc, exp_mc); end
    end
    n_tests++; if (obs_move[2:0] !== 3'd3) begin n_fail++; $display("FAIL tp_final: got %0d expected 3", obs_move[2:0]); end
  endtask

  task automatic test_p1_clear();
    press(1, 1, 10); model_event(1, 1, 1'b0);
    pulse_tick();
    n_tests++; if (obs_mc !== 2'b10) begin n_fail++; $display("FAIL p1_mc: got %b expected 10", obs_mc); end
    n_tests++; if (obs_move !== 6'o13) begin n_fail++; $display("FAIL p1_move: got %h expected %h", obs_move, 6'o13); end
    press(0, 2, 10); model_event(0, 2, 1'b0);
    bus.btn[btn_idx(1, 2)] = 1'b1;
    repeat (6) @(negedge clk);
    bus.clear = 1'b1;
    model_reset();
    @(negedge clk) bus.clear = 1'b0;
    n_tests++; if (bus.move !== 6'o55) begin n_fail++; $display("FAIL clear_move: got %h expected %h", bus.move, 6'o55); end
    n_tests++; if (bus.move_changed !== 2'b00) begin n_fail++; $display("FAIL clear_mc: got %b expected 00", bus.move_changed); end
    n_tests++; if (bus.queue_full !== 2'b00) begin n_fail++; $display("FAIL clear_qf: got %b expected 00", bus.queue_full); end
    repeat (4) @(negedge clk);
    bus.btn[btn_idx(1, 2)] = 1'b0;
    repeat (8) @(negedge clk);
    pulse_tick();
    n_tests++; if (obs_mc !== 2'b00) begin n_fail++; $display("FAIL clear_tick_mc: got %b expected 00", obs_mc); end
    n_tests++; if (obs_move !== exp_move) begin n_fail++; $display("FAIL clear_tick_move: got %h expected %h", obs_move, exp_move); end
  endtask

  task automatic test_reset_mid();
    press(0, 1, 10); model_event(0, 1, 1'b0);
    bus.btn[btn_idx(1, 2)] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_tests++; if ({bus.move_changed, bus.overflow} !== 4'b0000) begin n_fail++; $display("FAIL rmid_pulses: got %b expected 0000", {bus.move_changed, bus.overflow}); end
    rst = 1'b0;
    bus.btn = '0;
    @(negedge clk);
    n_tests++; if ({bus.move_changed, bus.overflow} !== 4'b0000) begin n_fail++; $display("FAIL rmid_pulses_after: got %b expected 0000", {bus.move_changed, bus.overflow}); end
    repeat (8) @(negedge clk);
    pulse_tick();
    n_tests++; if (obs_mc !== 2'b00) begin n_fail++; $display("FAIL rmid_tick_mc: got %b expected 00", obs_mc); end
    n_tests++; if (obs_move !== 6'o55) begin n_fail++; $display("FAIL rmid_tick_move: got %h expected %h", obs_move, 6'o55); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_glitch();
    test_filter();
    test_tick_push();
    test_p1_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
